sr_flag_arbiter: RTL and testbench

- Bank of NFLAG set/reset flags with set-dominant SR semantics: next = s | (~r & q), held in D-type storage.
- NREQ requesters share the flag bank through a round-robin arbiter; at most one command (set or clear of one indexed flag) is granted per cycle.
- Direct set/clear vectors apply every cycle alongside the granted command.
- Sits between the control agents and the status flags they publish.

---
 rtl/sr_flag_arbiter.sv | 143 ++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Set-dominant SR flag bank shared by NREQ requesters through a round-robin arbiter.
// Optional owner lock (req_lock/locked) is compiled in with SR_ARB_LOCK_EN.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_set,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NFLAG-1:0]     s_vec,
  input  logic [NFLAG-1:0]     r_vec,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     flags,
  output logic [NFLAG-1:0]     flags_n,
  output logic                 err
`ifdef SR_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]      req_lock,
  output logic                 locked
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NFLAG-1:0] flags_q, flags_d, flags_n_q;
  logic             err_q, err_d;
  logic [NREQ-1:0]  elig;
  logic             in_lock;
  logic [PW-1:0]    win;
  logic             win_vld;
  logic [IDXW-1:0]  win_idx;
  logic             win_set;
  logic [NFLAG-1:0] cmd_hit, s_eff, r_eff;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

`ifdef SR_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} lock_state_e;
  lock_state_e   state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;

  assign in_lock = (state_q == LOCK);
  assign locked  = in_lock;

  always_comb begin
    elig = req;
    if (in_lock) elig = req & (NREQ'(1) << owner_q);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (win_vld && req_lock[win]) begin
        state_d = LOCK;
        owner_d = win;
      end
      LOCK: if (!req[owner_q] || !req_lock[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  assign in_lock = 1'b0;
  assign elig    = req;
`endif

  // Handshake: a requester holds req/req_set/req_idx stable until it sees gnt=1
  // at a rising edge; the command commits on that edge and gnt is combinational.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && elig[wrap_add(ptr_q, i)]) begin
        win_vld = 1'b1;
        win     = wrap_add(ptr_q, i);
      end
    end
    if (rst) win_vld = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt = NREQ'(1) << win;
  end

  assign win_idx = req_idx[int'(win)*IDXW +: IDXW];
  assign win_set = req_set[win];

  // An out-of-range index matches no flag, so it only raises err.
  always_comb begin
    cmd_hit = '0;
    for (int f = 0; f < NFLAG; f++) begin
      cmd_hit[f] = win_vld && (int'(win_idx) == f);
    end
  end

  always_comb begin
    s_eff   = s_vec | (win_set ? cmd_hit : '0);
    r_eff   = r_vec | (win_set ? '0 : cmd_hit);
    flags_d = s_eff | (~r_eff & flags_q);
    err_d   = win_vld && (int'(win_idx) >= NFLAG);
    ptr_d   = ptr_q;
    if (win_vld && !in_lock) ptr_d = wrap_add(win, 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      flags_q   <= '0;
      flags_n_q <= '1;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      flags_q   <= flags_d;
      flags_n_q <= ~flags_d;
      err_q     <= err_d;
    end
  end

  assign flags   = flags_q;
  assign flags_n = flags_n_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: an NFLAG=8 and an NFLAG=6 instance share stimulus and
// are compared against a per-cycle behavioural model; SR_ARB_LOCK_EN adds lock checks.
module tb_sr_flag_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;
  localparam int EW   = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_set, req_lock;
  logic [11:0] req_idx;
  logic [7:0]  s_vec, r_vec;
  logic [3:0]  gnt8, gnt6;
  logic [7:0]  flags8, flags_n8;
  logic [5:0]  flags6, flags_n6;
  logic        err8, err6;
`ifdef SR_ARB_LOCK_EN
  logic        locked8, locked6;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [3:0] g_last;

  // model state: pointer, lock owner, flag banks
  int         m_ptr   = 0;
  bit         m_lock  = 1'b0;
  int         m_owner = 0;
  logic [7:0] m_f8    = '0;
  logic [5:0] m_f6    = '0;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_set(req_set), .req_idx(req_idx),
    .s_vec(s_vec), .r_vec(r_vec), .gnt(gnt8), .flags(flags8), .flags_n(flags_n8),
    .err(err8)
`ifdef SR_ARB_LOCK_EN
    , .req_lock(req_lock), .locked(locked8)
`endif
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) u_dut6 (
    .clk(clk), .rst(rst), .req(req), .req_set(req_set), .req_idx(req_idx),
    .s_vec(s_vec[5:0]), .r_vec(r_vec[5:0]), .gnt(gnt6), .flags(flags6),
    .flags_n(flags_n6), .err(err6)
`ifdef SR_ARB_LOCK_EN
    , .req_lock(req_lock), .locked(locked6)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One cycle: check combinational grant, advance the model, check registered state.
  task automatic step();
    int         win;
    logic [2:0] idx;
    logic [3:0] egnt;
    logic       e8, e6, sb, cb;
    logic [7:0] fn8;
    logic [5:0] fn6;
    logic [EW-1:0] ex;
    #1;
    win = -1;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (win < 0 && req[k] && (!m_lock || k == m_owner)) win = k;
      end
    end
    egnt = (win >= 0) ? 4'(1 << win) : 4'b0;
    g_last = gnt8;
    check("gnt", gnt8, egnt);
    check("gnt_nf6", gnt6, egnt);
    e8 = 1'b0;
    e6 = 1'b0;
    if (rst) begin
      m_ptr = 0; m_lock = 1'b0; m_owner = 0; m_f8 = '0; m_f6 = '0;
    end else begin
      idx = (win >= 0) ? req_idx[win*IDXW +: IDXW] : 3'd0;
      for (int b = 0; b < 8; b++) begin
        sb = s_vec[b] || (win >= 0 && req_set[win] && idx == 3'(b));
        cb = r_vec[b] || (win >= 0 && !req_set[win] && idx == 3'(b));
        if (sb) m_f8[b] = 1'b1;
        else if (cb) m_f8[b] = 1'b0;
        if (b < 6) begin
          if (sb) m_f6[b] = 1'b1;
          else if (cb) m_f6[b] = 1'b0;
        end
      end
      e6 = (win >= 0) && (idx >= 3'd6);
      if (m_lock) begin
        if (!req[m_owner] || !req_lock[m_owner]) m_lock = 1'b0;
      end else if (win >= 0) begin
        m_ptr = (win + 1) % NREQ;
        if (req_lock[win]) begin
          m_lock  = 1'b1;
          m_owner = win;
        end
      end
    end
    exp_q.push_back({m_lock, e6, m_f6, e8, m_f8});
    @(posedge clk);
    #1;
    ex  = exp_q.pop_front();
    fn8 = ~ex[7:0];
    fn6 = ~ex[14:9];
    check("flags", flags8, ex[7:0]);
    check("flags_n", flags_n8, fn8);
    check("err", err8, ex[8]);
    check("flags_nf6", flags6, ex[14:9]);
    check("flags_n_nf6", flags_n6, fn6);
    check("err_nf6", err6, ex[15]);
`ifdef SR_ARB_LOCK_EN
    check("locked", locked8, ex[16]);
    check("locked_nf6", locked6, ex[16]);
`endif
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] st,
                       input logic [11:0] ix, input logic [7:0] s, input logic [7:0] c,
                       input logic [3:0] lk);
    rst = r; req = q; req_set = st; req_idx = ix; s_vec = s; r_vec = c; req_lock = lk;
    step();
  endtask

  logic [3:0] rr_tab [6];

  initial begin
    rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // reset with every input active
    drive(1'b1, 4'hF, 4'hF, 12'hFFF, 8'hFF, 8'hFF, 4'hF);
    drive(1'b1, 4'hF, 4'hF, 12'hFFF, 8'hFF, 8'hFF, 4'hF);
    check("rst_gnt", g_last, 4'b0000);
    check("rst_flags", flags8, 8'h00);
    check("rst_flags_n", flags_n8, 8'hFF);
    check("rst_err", err8, 1'b0);
    drive(1'b0, 4'hF, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    check("first_gnt", g_last, 4'b0001);

    // single set then clear by requester 2 (idx 5)
    drive(1'b1, 4'h0, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    drive(1'b0, 4'b0100, 4'b0100, 12'h140, 8'h00, 8'h00, 4'h0);
    check("set_gnt", g_last, 4'b0100);
    check("set_flags", flags8, 8'h20);
    drive(1'b0, 4'b0100, 4'b0000, 12'h140, 8'h00, 8'h00, 4'h0);
    check("clr_flags", flags8, 8'h00);

    // round robin, each requester sets its own index
    drive(1'b1, 4'h0, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'hF, 4'hF, 12'h688, 8'h00, 8'h00, 4'h0);
      check("rr_seq", g_last, rr_tab[i]);
    end

    // set dominance
    drive(1'b1, 4'h0, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    drive(1'b0, 4'h0, 4'h0, 12'h000, 8'h08, 8'h08, 4'h0);
    check("sr_dom", flags8, 8'h08);
    drive(1'b0, 4'b0001, 4'b0000, 12'h003, 8'h08, 8'h00, 4'h0);
    check("sr_dom_cmd", flags8, 8'h08);

    // out-of-range index on the NFLAG=6 instance, then mid-stream reset
    drive(1'b1, 4'h0, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    drive(1'b0, 4'b0010, 4'b0010, 12'h038, 8'h00, 8'h00, 4'h0);
    check("oor_gnt", g_last, 4'b0010);
    check("oor_err", err6, 1'b1);
    check("oor_flags", flags6, 6'h00);
    drive(1'b0, 4'h0, 4'h0, 12'h000, 8'h00, 8'h00, 4'h0);
    check("oor_err_pulse", err6, 1'b0);
    drive(1'b0, 4'b0001, 4'b0001, 12'h006, 8'h11, 8'h00, 4'h0);
    drive(1'b1, 4'hF, 4'hF, 12'h000, 8'hFF, 8'h00, 4'h0);
    check("mid_rst_flags", flags8, 8'h00);
    check("mid_rst_err", err6, 1'b0);

`ifdef SR_ARB_LOCK_EN
    drive(1'b0, 4'b1000, 4'b1000, 12'h200, 8'h00, 8'h00, 4'b1000);
    check("lock_gnt", g_last, 4'b1000);
    check("lock_on", locked8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1011, 4'b1011, 12'(i << 9), 8'h00, 8'h00, 4'b1000);
      check("lock_starve", g_last, 4'b1000);
    end
    drive(1'b0, 4'b1011, 4'b1011, 12'h800, 8'h00, 8'h00, 4'b0000);
    check("unlock_gnt", g_last, 4'b1000);
    check("unlock", locked8, 1'b0);
    drive(1'b0, 4'b0011, 4'b0011, 12'h000, 8'h00, 8'h00, 4'b0000);
    check("after_unlock", g_last, 4'b0001);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] lk;
      lk = '0;
`ifdef SR_ARB_LOCK_EN
      lk = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
`endif
      drive(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            12'($urandom_range(0, 4095)),
            8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
            lk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
